// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a req/valid memory
// handshake, and holds it for the decoder. Optional opcode check under FETCH_OPCHECK_EN.
module instr_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_valid,
  output logic [WIDTH-1:0] instruction,
  output logic [WIDTH-1:0] pc_out,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             take_branch,
  input  logic [WIDTH-1:0] branch_target,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] flush_addr_q, flush_addr_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_out_q, pc_out_d;
  logic             valid_q, valid_d;
  logic             capture;
  logic             halted;

`ifdef FETCH_OPCHECK_EN
  logic illegal_q, illegal_d;

  function automatic logic opcode_legal(input logic [6:0] op);
    return (op == 7'b1100011) || (op == 7'b0110011) ||
           (op == 7'b0100011) || (op == 7'b0000011);
  endfunction

  // Capture sets the flag; a redirect out of HOLD is the only way to clear it.
  always_comb begin
    illegal_d = illegal_q;
    if (capture)
      illegal_d = !opcode_legal(imem_rdata[6:0]);
    else if (state_q == HOLD && take_branch)
      illegal_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign halted  = illegal_q;
  assign illegal = illegal_q;
`else
  assign halted  = 1'b0;
  assign illegal = 1'b0;
`endif

  // A word returned in the same cycle as a redirect is dropped, never captured.
  assign capture = (state_q == REQ) && imem_valid && !take_branch;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush_addr_d = flush_addr_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    imem_req     = 1'b0;
    imem_addr    = pc_q;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (capture) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          pc_d     = pc_q + WIDTH'(4);
          valid_d  = 1'b1;
          state_d  = HOLD;
        end else if (take_branch && !imem_valid) begin
          flush_addr_d = pc_q;
          state_d      = FLUSH;
        end
      end
      HOLD: begin
        if (take_branch || (instr_ready && !halted)) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      FLUSH: begin
        // The abandoned request keeps its original address until the memory completes it.
        imem_req  = 1'b1;
        imem_addr = flush_addr_q;
        if (imem_valid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (take_branch) pc_d = {branch_target[WIDTH-1:2], 2'b00};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      flush_addr_q <= '0;
      instr_q      <= '0;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_addr_q <= flush_addr_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
    end
  end

  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-side producer for the single-cycle-decode datapath: owns the PC, reads words from instruction memory over a req/valid handshake, presents one instruction at a time to the decoder over a valid/ready handshake.
- Accepts a redirect (taken branch) from the execute side; flushes the held or in-flight word and refetches from the target.
- One outstanding memory request at a time.

Parameters:
- WIDTH, 32, data and address width in bits.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IMEM_REQ  out  1  fetch request; held high until IMEM_VALID.
- IMEM_ADDR  out  WIDTH  byte address; stable while IMEM_REQ=1 and IMEM_VALID=0.
- IMEM_RDATA  in  WIDTH  read word; sampled only when IMEM_REQ&IMEM_VALID.
- IMEM_VALID  in  1  completes the request; may assert in the same cycle as IMEM_REQ.
- INSTRUCTION  out  WIDTH  held instruction word to the decoder.
- PC_OUT  out  WIDTH  address of INSTRUCTION.
- INSTR_VALID  out  1  INSTRUCTION/PC_OUT are valid.
- INSTR_READY  in  1  decoder accepts; transfer = INSTR_VALID&INSTR_READY.
- TAKE_BRANCH  in  1  redirect strobe, one cycle.
- BRANCH_TARGET  in  WIDTH  redirect address; bits [1:0] ignored (forced 0).
- ILLEGAL  out  1  opcode check flag (see Optional Feature).

Behaviour:
- Reset (async, RST_N=0): state IDLE, PC=RESET_PC, IMEM_REQ=0, INSTR_VALID=0, INSTRUCTION=0, PC_OUT=0, ILLEGAL=0. Reset mid-request abandons it; any late IMEM_VALID is ignored.
- FSM states: IDLE, REQ, HOLD, FLUSH.
- IDLE: next cycle goes to REQ unconditionally.
- REQ: IMEM_REQ=1, IMEM_ADDR=PC.
  - On IMEM_VALID: INSTRUCTION<=IMEM_RDATA, PC_OUT<=PC, PC<=PC+4 (mod 2^WIDTH; 32'hFFFF_FFFC wraps to 0), INSTR_VALID<=1, go HOLD.
- HOLD: IMEM_REQ=0; outputs stable until a transfer.
  - On transfer: INSTR_VALID<=0, go REQ. Minimum spacing is 2 cycles per instruction with zero-latency memory.
- Redirect priority: TAKE_BRANCH beats sequential increment in every state.
  - All states: PC<={BRANCH_TARGET[WIDTH-1:2],2'b00}.
  - HOLD: INSTR_VALID<=0 next cycle, go REQ. If INSTR_READY is high in the same cycle, that transfer still counts as accepted.
  - REQ with IMEM_VALID in the same cycle: returned word dropped (INSTR_VALID stays 0), go REQ at target.
  - REQ without IMEM_VALID: go FLUSH.
  - IDLE/FLUSH: only PC updates; state flow unchanged.
- FLUSH: IMEM_REQ=1 with the old address held stable until IMEM_VALID; data dropped; then go REQ at the (latest) redirected PC.
- A second TAKE_BRANCH during FLUSH overwrites PC; last target wins.
- Latency: REQ entry to INSTR_VALID = memory latency + 1 cycle (registered output).

Optional Feature:
- Macro FETCH_OPCHECK_EN.
- Defined: on capture, ILLEGAL<=1 if IMEM_RDATA[6:0] is not one of 7'b1100011, 7'b0110011, 7'b0100011, 7'b0000011.
  - With ILLEGAL=1 the unit stays in HOLD with INSTR_VALID=1 and ignores INSTR_READY; no further requests are issued.
  - Cleared only by TAKE_BRANCH (ILLEGAL<=0, normal redirect) or reset.
- Not defined: ILLEGAL tied 0, no checking logic.

Test Plan:
- Reset release, zero-latency memory returning 32'h00000033, INSTR_READY=1 -> first IMEM_ADDR=0; PC_OUT sequence 0,4,8 with one transfer every 2 cycles.
- Memory latency 3, INSTR_READY low for 5 cycles -> IMEM_REQ/IMEM_ADDR stable until IMEM_VALID; INSTRUCTION/PC_OUT stable and INSTR_VALID high through the stall; no new request issued.
- TAKE_BRANCH, BRANCH_TARGET=32'h0000_0103 in HOLD -> INSTR_VALID drops, next IMEM_ADDR=32'h100.
- TAKE_BRANCH during REQ with IMEM_VALID 2 cycles later -> FLUSH keeps the old address; returned word never appears on INSTRUCTION; next request goes to the target.
- RESET_PC=32'hFFFF_FFFC -> PC_OUT FFFF_FFFC, then 0; RST_N low mid-REQ -> outputs return to reset values immediately.
- FETCH_OPCHECK_EN defined, memory returns 32'h00000013 -> ILLEGAL=1, unit halted in HOLD despite INSTR_READY; TAKE_BRANCH clears it and resumes at the target.
